// File: rtl/led_shifter.sv
// Serial output stage: pushes the parallel LED pattern MSB-first into a
// 74HC595-style shift register and pulses its storage latch on every change.
module led_shifter #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] leds,
    output logic             ser_data,
    output logic             ser_clock,
    output logic             ser_latch,
    output logic             busy
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        LATCH
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [DW-1:0]    divcnt, divcnt_n;
    logic             pending, pending_n;
    logic             ser_data_n, ser_clock_n, ser_latch_n, busy_n;

    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_n   = state;
        shadow_n  = shadow;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        divcnt_n  = divcnt;
        pending_n = pending;

        unique case (state)
            IDLE: begin
                if (pending || (leds != shadow)) begin
                    shreg_n   = leds;
                    shadow_n  = leds;
                    pending_n = 1'b0;
                    bitcnt_n  = '0;
                    divcnt_n  = '0;
                    state_n   = LOW;
                end
            end
            LOW: begin
                if (divcnt == DIV_LAST) begin
                    divcnt_n = '0;
                    state_n  = HIGH;
                end else begin
                    divcnt_n = divcnt + 1'b1;
                end
            end
            HIGH: begin
                if (divcnt == DIV_LAST) begin
                    divcnt_n = '0;
                    if (bitcnt == BIT_LAST) begin
                        state_n = LATCH;
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                        shreg_n  = shreg << 1;
                        state_n  = LOW;
                    end
                end else begin
                    divcnt_n = divcnt + 1'b1;
                end
            end
            LATCH: begin
                if (divcnt == DIV_LAST) begin
                    divcnt_n = '0;
                    state_n  = IDLE;
                end else begin
                    divcnt_n = divcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each pin is a single flop
    // that changes on the same edge as the state it reflects.
    always_comb begin
        busy_n      = (state_n != IDLE);
        ser_clock_n = (state_n == HIGH);
        ser_latch_n = (state_n == LATCH);
        ser_data_n  = ((state_n == LOW) || (state_n == HIGH)) ? shreg_n[WIDTH-1] : 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            shadow    <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            divcnt    <= '0;
            pending   <= 1'b1;
            ser_data  <= 1'b0;
            ser_clock <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            shreg     <= shreg_n;
            bitcnt    <= bitcnt_n;
            divcnt    <= divcnt_n;
            pending   <= pending_n;
            ser_data  <= ser_data_n;
            ser_clock <= ser_clock_n;
            ser_latch <= ser_latch_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_led_shifter.sv
// Bench for led_shifter: a default 8x4 instance and a 4x1 instance, each
// checked every cycle against a transfer-timeline model and a 595 receiver.
module tb_led_shifter;

    localparam int TOTAL_A = 2 * 4 * 8 + 4;
    localparam int TOTAL_B = 2 * 1 * 4 + 1;

    logic       clock = 1'b0;
    logic       reset_b = 1'b1;
    logic [7:0] leds_a = 8'h00;
    logic [3:0] leds_b = 4'h0;
    logic       ser_data_a, ser_clock_a, ser_latch_a, busy_a;
    logic       ser_data_b, ser_clock_b, ser_latch_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    led_shifter #(.WIDTH(8), .DIV(4)) dut_a (
        .clock(clock), .reset_b(reset_b), .leds(leds_a),
        .ser_data(ser_data_a), .ser_clock(ser_clock_a),
        .ser_latch(ser_latch_a), .busy(busy_a)
    );

    led_shifter #(.WIDTH(4), .DIV(1)) dut_b (
        .clock(clock), .reset_b(reset_b), .leds(leds_b),
        .ser_data(ser_data_b), .ser_clock(ser_clock_b),
        .ser_latch(ser_latch_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected {busy, ser_clock, ser_latch, ser_data} at offset t of a transfer.
    function automatic logic [3:0] expect_out(input bit act, input int t, input logic [7:0] val,
                                              input int w, input int d);
        logic [3:0] r;
        int k;
        r = 4'b0000;
        if (act) begin
            k = t / (2 * d);
            if (k < w) r = {1'b1, ((t % (2 * d)) >= d), 1'b0, val[w-1-k]};
            else       r = 4'b1010;
        end
        return r;
    endfunction

    // Transfer timeline models: when a transfer starts, with what value, and how far in.
    bit         ma_act, ma_pend, mb_act, mb_pend;
    int         ma_t, mb_t;
    logic [7:0] ma_val, ma_shadow;
    logic [3:0] mb_val, mb_shadow;

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            ma_act <= 1'b0; ma_t <= 0; ma_val <= '0; ma_shadow <= '0; ma_pend <= 1'b1;
        end else if (!ma_act) begin
            if (ma_pend || (leds_a != ma_shadow)) begin
                ma_act <= 1'b1; ma_t <= 0; ma_val <= leds_a; ma_shadow <= leds_a; ma_pend <= 1'b0;
            end
        end else if (ma_t == TOTAL_A - 1) begin
            ma_act <= 1'b0;
        end else begin
            ma_t <= ma_t + 1;
        end
    end

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            mb_act <= 1'b0; mb_t <= 0; mb_val <= '0; mb_shadow <= '0; mb_pend <= 1'b1;
        end else if (!mb_act) begin
            if (mb_pend || (leds_b != mb_shadow)) begin
                mb_act <= 1'b1; mb_t <= 0; mb_val <= leds_b; mb_shadow <= leds_b; mb_pend <= 1'b0;
            end
        end else if (mb_t == TOTAL_B - 1) begin
            mb_act <= 1'b0;
        end else begin
            mb_t <= mb_t + 1;
        end
    end

    // External 74HC595 receivers, preset to all ones so a latched zero is visible.
    logic [7:0] sr_a = 8'hFF, out_a = 8'hFF;
    logic [3:0] sr_b = 4'hF,  out_b = 4'hF;
    logic [7:0] lq_a[$];
    int rise_a = 0, rise_b = 0, pulse_a = 0, pulse_b = 0;

    always @(posedge ser_clock_a) begin
        sr_a   <= {sr_a[6:0], ser_data_a};
        rise_a <= rise_a + 1;
    end
    always @(posedge ser_latch_a) begin
        out_a   <= sr_a;
        pulse_a <= pulse_a + 1;
        lq_a.push_back(sr_a);
    end
    always @(posedge ser_clock_b) begin
        sr_b   <= {sr_b[2:0], ser_data_b};
        rise_b <= rise_b + 1;
    end
    always @(posedge ser_latch_b) begin
        out_b   <= sr_b;
        pulse_b <= pulse_b + 1;
    end

    // Per-cycle comparison against the models, plus level counters.
    int busy_cyc_a = 0, latch_cyc_a = 0, busy_cyc_b = 0, sclk_cyc_b = 0;

    always @(negedge clock) begin
        check("cycle_a", 32'({busy_a, ser_clock_a, ser_latch_a, ser_data_a}),
              32'(expect_out(ma_act, ma_t, ma_val, 8, 4)));
        check("cycle_b", 32'({busy_b, ser_clock_b, ser_latch_b, ser_data_b}),
              32'(expect_out(mb_act, mb_t, {4'h0, mb_val}, 4, 1)));
        busy_cyc_a  <= busy_cyc_a + (busy_a ? 1 : 0);
        latch_cyc_a <= latch_cyc_a + (ser_latch_a ? 1 : 0);
        busy_cyc_b  <= busy_cyc_b + (busy_b ? 1 : 0);
        sclk_cyc_b  <= sclk_cyc_b + (ser_clock_b ? 1 : 0);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    int b0, r0, p0, l0, q0;

    task automatic snap_a();
        b0 = busy_cyc_a; r0 = rise_a; p0 = pulse_a; l0 = latch_cyc_a; q0 = lq_a.size();
    endtask

    initial begin
        #1 reset_b = 1'b0;
        cycles(3);
        check("reset_outputs", 32'({busy_a, ser_clock_a, ser_latch_a, ser_data_a}), 32'h0);

        // Post-reset refresh of an all-zero pattern.
        snap_a();
        reset_b = 1'b1;
        cycles(80);
        check("refresh_busy_cycles", 32'(busy_cyc_a - b0), 32'd68);
        check("refresh_clock_rises", 32'(rise_a - r0), 32'd8);
        check("refresh_latch_pulses", 32'(pulse_a - p0), 32'd1);
        check("refresh_latch_width", 32'(latch_cyc_a - l0), 32'd4);
        check("refresh_latched", 32'(out_a), 32'h00);
        snap_a();
        cycles(100);
        check("quiet_busy", 32'(busy_cyc_a - b0), 32'd0);
        check("quiet_rises", 32'(rise_a - r0), 32'd0);

        // Single pattern: bits 1,0,1,0,0,1,0,1 on successive rises.
        snap_a();
        leds_a = 8'hA5;
        cycles(80);
        check("a5_rises", 32'(rise_a - r0), 32'd8);
        check("a5_bits", 32'(sr_a), 32'b1010_0101);
        check("a5_latched", 32'(out_a), 32'hA5);

        // Changes mid-transfer: 01 lands, 80 skipped, FF lands after one idle cycle.
        snap_a();
        leds_a = 8'h01;
        cycles(10);
        leds_a = 8'h80;
        cycles(20);
        leds_a = 8'hFF;
        cycles(150);
        check("change_pulses", 32'(pulse_a - p0), 32'd2);
        check("change_busy_cycles", 32'(busy_cyc_a - b0), 32'd136);
        if (lq_a.size() >= q0 + 2) begin
            check("change_first", 32'(lq_a[q0]), 32'h01);
            check("change_second", 32'(lq_a[q0 + 1]), 32'hFF);
        end else begin
            check("change_latch_count", 32'(lq_a.size() - q0), 32'd2);
        end

        // Stable input produces no activity.
        leds_a = 8'h3C;
        cycles(80);
        snap_a();
        cycles(500);
        check("stable_busy", 32'(busy_cyc_a - b0), 32'd0);
        check("stable_rises", 32'(rise_a - r0), 32'd0);
        check("stable_pulses", 32'(pulse_a - p0), 32'd0);
        check("stable_latched", 32'(out_a), 32'h3C);

        // Reset in the middle of a transfer: outputs clear at once, full resend follows.
        snap_a();
        leds_a = 8'hC3;
        cycles(21);
        #1 reset_b = 1'b0;
        #1 check("midreset_outputs", 32'({busy_a, ser_clock_a, ser_latch_a, ser_data_a}), 32'h0);
        check("midreset_no_latch", 32'(pulse_a - p0), 32'd0);
        cycles(3);
        reset_b = 1'b1;
        cycles(80);
        check("midreset_pulses", 32'(pulse_a - p0), 32'd1);
        check("midreset_latched", 32'(out_a), 32'hC3);

        // Narrow, fast instance: WIDTH=4, DIV=1.
        b0 = busy_cyc_b; r0 = rise_b; p0 = pulse_b; l0 = sclk_cyc_b;
        leds_b = 4'b1001;
        cycles(20);
        check("sweep_busy_cycles", 32'(busy_cyc_b - b0), 32'd9);
        check("sweep_rises", 32'(rise_b - r0), 32'd4);
        check("sweep_clock_high", 32'(sclk_cyc_b - l0), 32'd4);
        check("sweep_pulses", 32'(pulse_b - p0), 32'd1);
        check("sweep_latched", 32'(out_b), 32'b1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
